wb_mem_bridge: RTL and testbench

Wishbone single-access master between the pipeline memory stage and the data-side Wishbone bus (CLINT and the other data slaves).
- Turns one load/store request into one classic Wishbone cycle: byte-lane select, store-data replication, load extraction with sign/zero extension.
- Holds the pipeline with a stall request until the cycle ends.
- Reports misaligned accesses and bus timeouts to the trap logic.

---
 rtl/wb_mem_bridge_pkg.sv | 31 +++
 rtl/wb_lane_align.sv | 43 ++++
 rtl/wb_mem_bridge.sv | 119 +++++++++++
 tb/tb_wb_mem_bridge.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_mem_bridge_pkg.sv
// Shared constants and types for the data-side Wishbone bridge.
// Size/error codes match the memory-stage encodings used by the pipeline.
package wb_mem_bridge_pkg;

  localparam int          RegBus   = 32;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic [1:0] MemSizeByte = 2'b00;
  localparam logic [1:0] MemSizeHalf = 2'b01;
  localparam logic [1:0] MemSizeWord = 2'b10;

  localparam logic [1:0] MemErrNone     = 2'b00;
  localparam logic [1:0] MemErrMisalign = 2'b01;
  localparam logic [1:0] MemErrTimeout  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Size code 11 behaves as a word.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MemSizeByte: return 1'b0;
      MemSizeHalf: return off[0];
      default:     return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/wb_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// Purely combinational; the bridge registers everything it produces.
module wb_lane_align
  import wb_mem_bridge_pkg::*;
(
  input  logic [1:0]        i_size,
  input  logic [1:0]        i_off,
  input  logic              i_unsigned,
  input  logic [RegBus-1:0] i_wdat,
  input  logic [RegBus-1:0] i_rdat,
  output logic [3:0]        o_sel,
  output logic [RegBus-1:0] o_wdat,
  output logic [RegBus-1:0] o_rdat
);

  logic [RegBus-1:0] w_rshift;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;

  assign w_rshift = i_rdat >> {i_off, 3'b000};
  assign w_byte   = w_rshift[7:0];
  assign w_half   = i_off[1] ? i_rdat[31:16] : i_rdat[15:0];

  always_comb begin
    o_sel  = 4'b1111;
    o_wdat = i_wdat;
    o_rdat = i_rdat;
    case (i_size)
      MemSizeByte: begin
        o_sel  = 4'b0001 << i_off;
        o_wdat = {4{i_wdat[7:0]}};
        o_rdat = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      end
      MemSizeHalf: begin
        o_sel  = 4'b0011 << i_off;
        o_wdat = {2{i_wdat[15:0]}};
        o_rdat = {{16{~i_unsigned & w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_mem_bridge.sv
// Single-access Wishbone master for the memory stage: one load/store per
// classic bus cycle, pipeline stall while in flight, misalign/timeout errors.
module wb_mem_bridge
  import wb_mem_bridge_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [RegBus-1:0] mem_addr_i,
  input  logic [RegBus-1:0] mem_data_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_unsigned_i,
  input  logic              flush_i,
  output logic [RegBus-1:0] mem_data_o,
  output logic [1:0]        mem_err_o,
  output logic              stall_req_o,
  output logic [RegBus-1:0] wb_adr_o,
  output logic [RegBus-1:0] wb_dat_o,
  input  logic [RegBus-1:0] wb_dat_i,
  output logic [3:0]        wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  input  logic              wb_ack_i
);

  state_e            r_state, w_next;
  logic [7:0]        r_cnt;
  logic              r_cyc;
  logic              w_mis, w_timeout;
  logic [3:0]        w_sel;
  logic [RegBus-1:0] w_wdat, w_ldat;

  assign w_mis     = misaligned(mem_size_i, mem_addr_i[1:0]);
  assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));

  wb_lane_align u_align (
    .i_size    (mem_size_i),
    .i_off     (mem_addr_i[1:0]),
    .i_unsigned(mem_unsigned_i),
    .i_wdat    (mem_data_i),
    .i_rdat    (wb_dat_i),
    .o_sel     (w_sel),
    .o_wdat    (w_wdat),
    .o_rdat    (w_ldat)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush_i) w_next = ST_IDLE;
    else begin
      case (r_state)
        ST_IDLE: if (mem_ce_i) w_next = w_mis ? ST_DONE : ST_BUSY;
        ST_BUSY: if (wb_ack_i || w_timeout) w_next = ST_DONE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Registered outputs; ack is only honoured while BUSY.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cyc      <= 1'b0;
      r_cnt      <= '0;
      wb_adr_o   <= ZeroWord;
      wb_dat_o   <= ZeroWord;
      wb_sel_o   <= '0;
      wb_we_o    <= 1'b0;
      mem_data_o <= ZeroWord;
      mem_err_o  <= MemErrNone;
    end else if (flush_i) begin
      r_cyc     <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_sel_o  <= '0;
      mem_err_o <= MemErrNone;
    end else begin
      case (r_state)
        ST_IDLE: if (mem_ce_i) begin
          if (w_mis) mem_err_o <= MemErrMisalign;
          else begin
            wb_adr_o <= {mem_addr_i[RegBus-1:2], 2'b00};
            wb_dat_o <= w_wdat;
            wb_sel_o <= w_sel;
            wb_we_o  <= mem_we_i;
            r_cyc    <= 1'b1;
            r_cnt    <= '0;
          end
        end
        ST_BUSY: begin
          if (wb_ack_i) begin
            mem_data_o <= wb_we_o ? ZeroWord : w_ldat;
            mem_err_o  <= MemErrNone;
            r_cyc      <= 1'b0;
          end else if (w_timeout) begin
            mem_data_o <= ZeroWord;
            mem_err_o  <= MemErrTimeout;
            r_cyc      <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign wb_cyc_o    = r_cyc;
  assign wb_stb_o    = r_cyc;
  assign stall_req_o = mem_ce_i && (r_state != ST_DONE) && !wb_rst_i;

endmodule

// File: tb/tb_wb_mem_bridge.sv
// Bench for wb_mem_bridge: directed + random accesses against a byte-arithmetic
// model, with a CLINT-like slave that acks the cycle after it sees stb.
module tb_wb_mem_bridge;

  localparam int          TO    = 4;
  localparam logic [31:0] CLINT = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ce_i, mem_we_i, mem_unsigned_i, flush_i;
  logic [31:0] mem_addr_i, mem_data_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_data_o;
  logic [1:0]  mem_err_o;
  logic        stall_req_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;

  logic        ack_auto, ack_man, ack_en;
  logic [31:0] rdata;
  int          total = 0;
  int          bad   = 0;

  wb_mem_bridge #(.TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
    .flush_i(flush_i), .mem_data_o(mem_data_o), .mem_err_o(mem_err_o),
    .stall_req_o(stall_req_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  assign wb_ack_i = ack_auto | ack_man;
  assign wb_dat_i = rdata;

  always @(posedge clk or posedge rst) begin
    if (rst) ack_auto <= 1'b0;
    else     ack_auto <= ack_en && wb_cyc_o && wb_stb_o && !ack_auto;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access width in bytes, lanes and extension by arithmetic.
  function automatic int nb(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
    int off = int'(a[1:0]);
    return (off % nb(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_sel(input logic [1:0] sz, input logic [31:0] a);
    int m = ((1 << nb(sz)) - 1) << a[1:0];
    return 4'(m);
  endfunction

  function automatic logic [31:0] m_dat(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb(sz)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a,
                                         input logic uns, input logic [31:0] rd);
    int          n = nb(sz);
    logic [31:0] v, mask;
    v    = rd >> (8 * int'(a[1:0]));
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v    = v & mask;
    if (!uns && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic txn(input logic we, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] d, input logic uns, input logic [31:0] rd,
                     input logic stray, input string tag);
    logic mis;
    int   stalls;
    bit   done;
    mis = m_mis(sz, a);
    rdata = rd; ack_en = 1'b1; ack_man = stray;
    mem_we_i = we; mem_size_i = sz; mem_addr_i = a; mem_data_i = d;
    mem_unsigned_i = uns; mem_ce_i = 1'b1;
    #1;
    chk({tag, "_t0_stall"}, 32'(stall_req_o), 32'd1);
    chk({tag, "_t0_cyc"}, 32'(wb_cyc_o), 32'd0);
    stalls = 1; done = 0;
    for (int c = 1; c <= 20 && !done; c++) begin
      @(posedge clk); #1;
      ack_man = 1'b0;
      if (!stall_req_o) done = 1; else stalls++;
      if (c == 1) begin
        if (mis) chk({tag, "_mis_cyc"}, 32'(wb_cyc_o), 32'd0);
        else begin
          chk({tag, "_t1_cyc"}, 32'(wb_cyc_o & wb_stb_o), 32'd1);
          chk({tag, "_t1_adr"}, wb_adr_o, {a[31:2], 2'b00});
          chk({tag, "_t1_sel"}, 32'(wb_sel_o), 32'(m_sel(sz, a)));
          chk({tag, "_t1_we"}, 32'(wb_we_o), 32'(we));
          if (we) chk({tag, "_t1_dat"}, wb_dat_o, m_dat(sz, d));
        end
      end
    end
    if (!done) begin
      total++; bad++;
      $error("FAIL %s_done observed=stalled expected=done within 20 cycles", tag);
    end else begin
      chk({tag, "_stalls"}, 32'(stalls), mis ? 32'd1 : 32'd3);
      chk({tag, "_err"}, 32'(mem_err_o), mis ? 32'd1 : 32'd0);
      chk({tag, "_done_cyc"}, 32'(wb_cyc_o), 32'd0);
      if (!mis) chk({tag, "_data"}, mem_data_o, we ? 32'd0 : m_load(sz, a, uns, rd));
    end
    @(posedge clk); #1;
    mem_ce_i = 1'b0;
    #1;
    chk({tag, "_idle_cyc"}, 32'(wb_cyc_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1; ack_en = 1'b0; ack_man = 1'b0; flush_i = 1'b0; rdata = '0;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = '0; mem_data_i = '0;
    mem_size_i = 2'b10; mem_unsigned_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cyc",   32'(wb_cyc_o | wb_stb_o), 32'd0);
    chk("rst_sel",   32'(wb_sel_o), 32'd0);
    chk("rst_adr",   wb_adr_o, 32'd0);
    chk("rst_dat",   wb_dat_o, 32'd0);
    chk("rst_we",    32'(wb_we_o), 32'd0);
    chk("rst_data",  mem_data_o, 32'd0);
    chk("rst_err",   32'(mem_err_o), 32'd0);
    chk("rst_stall", 32'(stall_req_o), 32'd0);
    rst = 1'b0; mem_ce_i = 1'b0;
    @(posedge clk); #1;

    // Directed accesses from the test plan
    txn(1'b1, 2'b10, CLINT + 32'h4000, 32'h0000_0010, 1'b0, 32'h0, 1'b0, "st_w");
    txn(1'b1, 2'b00, CLINT + 32'h4003, 32'h0000_00A5, 1'b0, 32'h0, 1'b0, "st_b");
    txn(1'b1, 2'b01, CLINT + 32'h4002, 32'h0000_1234, 1'b0, 32'h0, 1'b0, "st_h");
    txn(1'b0, 2'b00, CLINT + 32'h4000, 32'h0, 1'b0, 32'h8081_82F3, 1'b0, "ld_bs0");
    txn(1'b0, 2'b00, CLINT + 32'h4003, 32'h0, 1'b1, 32'h8081_82F3, 1'b0, "ld_bu3");
    txn(1'b0, 2'b01, CLINT + 32'h4002, 32'h0, 1'b0, 32'h8081_82F3, 1'b0, "ld_hs2");
    txn(1'b0, 2'b11, CLINT + 32'h4004, 32'h0, 1'b0, 32'h1357_9BDF, 1'b0, "ld_w11");
    txn(1'b0, 2'b10, CLINT + 32'h4002, 32'h0, 1'b0, 32'h8081_82F3, 1'b0, "mis_w");
    txn(1'b0, 2'b01, CLINT + 32'h4001, 32'h0, 1'b0, 32'h8081_82F3, 1'b0, "mis_h");

    for (int i = 0; i < 40; i++) begin
      txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
          1'($urandom_range(0, 1)), $urandom, 1'b0, "rnd");
    end

    // Slave never acks
    ack_en = 1'b0; rdata = 32'hDEAD_BEEF;
    mem_we_i = 1'b0; mem_size_i = 2'b10; mem_addr_i = CLINT + 32'h10; mem_ce_i = 1'b1;
    #1;
    chk("to_t0_stall", 32'(stall_req_o), 32'd1);
    for (int c = 1; c <= TO; c++) begin
      @(posedge clk); #1;
      chk("to_busy_cyc", 32'(wb_cyc_o), 32'd1);
      chk("to_busy_stall", 32'(stall_req_o), 32'd1);
    end
    @(posedge clk); #1;
    chk("to_done_stall", 32'(stall_req_o), 32'd0);
    chk("to_done_cyc", 32'(wb_cyc_o), 32'd0);
    chk("to_err", 32'(mem_err_o), 32'd2);
    chk("to_data", mem_data_o, 32'd0);
    @(posedge clk); #1;
    mem_ce_i = 1'b0;
    @(posedge clk); #1;

    // Flush while BUSY, stray ack, then a fresh request completes
    ack_en = 1'b0;
    mem_we_i = 1'b0; mem_size_i = 2'b10; mem_addr_i = CLINT + 32'h8; mem_ce_i = 1'b1;
    @(posedge clk); #1;
    chk("fl_t1_cyc", 32'(wb_cyc_o), 32'd1);
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("fl_t3_cyc", 32'(wb_cyc_o), 32'd0);
    chk("fl_t3_err", 32'(mem_err_o), 32'd0);
    txn(1'b0, 2'b00, CLINT + 32'h4001, 32'h0, 1'b0, 32'h0000_7F00, 1'b1, "fl_new");

    // Asynchronous reset mid-BUSY
    ack_en = 1'b0;
    mem_we_i = 1'b1; mem_size_i = 2'b10; mem_addr_i = CLINT; mem_data_i = 32'h55AA_55AA;
    mem_ce_i = 1'b1;
    @(posedge clk); #1;
    chk("ar_busy_cyc", 32'(wb_cyc_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_cyc", 32'(wb_cyc_o | wb_stb_o), 32'd0);
    chk("ar_stall", 32'(stall_req_o), 32'd0);
    #1 rst = 1'b0;
    mem_ce_i = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
